// File: rtl/seq_adder_pkg.sv
// Shared definitions for the digit-serial accumulating adder.
//   - operation mode codes driven on the 'mode' port
//   - FSM state type
//   - helpers deriving the digit-step count and step-counter width
package seq_adder_pkg;

  localparam logic [1:0] MODE_ADD     = 2'b00;  // A + B
  localparam logic [1:0] MODE_SUB     = 2'b01;  // A - B
  localparam logic [1:0] MODE_ACC_ADD = 2'b10;  // operand A combined with acc, add
  localparam logic [1:0] MODE_ACC_SUB = 2'b11;  // operand A combined with acc, subtract

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit cycles per operation.
  function automatic int unsigned steps_of(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // Width of a counter able to hold 0..STEPS.
  function automatic int unsigned cnt_bits(input int unsigned width, input int unsigned digit);
    return $clog2(width / digit + 1);
  endfunction

endpackage

// File: rtl/seq_accum_adder_digit.sv
// digit_adder: combinational DIGIT-bit ripple-carry adder.
//   a, b      : DIGIT-bit operand slices
//   cin       : carry into bit 0
//   s         : DIGIT-bit sum slice
//   cout      : carry out of the top bit
//   c_msb_in  : carry into the top bit (overflow detection on the last digit)
module digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  always_comb begin
    logic [DIGIT:0] c;
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout     = c[DIGIT];
    c_msb_in = c[DIGIT-1];
  end

endmodule

// File: rtl/seq_accum_adder.sv
// seq_accum_adder: digit-serial adder/subtractor with an internal accumulator.
// Processes DIGIT bits per clock, STEPS = WIDTH/DIGIT cycles per operation.
//   clk, rst (sync, active high)
//   start, mode[1:0], clr_acc    : control, sampled only in IDLE/DONE
//   A, B [WIDTH]                 : operands, latched on accepted start
//   sum [WIDTH], cr_out, ovf     : result, updated only at completion
//   acc [WIDTH]                  : accumulator (written by modes 10/11)
//   busy                         : digits being processed
//   done                         : one-cycle completion pulse
module seq_accum_adder
  import seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             clr_acc,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] sum,
  output logic             cr_out,
  output logic             ovf,
  output logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    STEPS = steps_of(WIDTH, DIGIT);
  localparam int unsigned    CW    = cnt_bits(WIDTH, DIGIT);
  localparam logic [CW-1:0]  LAST  = CW'(STEPS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic             r_cr;
  logic             r_ovf;
  logic             r_to_acc;
  logic [CW-1:0]    r_cnt;

  logic             w_ready;
  logic             w_accept;
  logic             w_last;
  logic             w_is_sub;
  logic             w_use_acc;
  logic [WIDTH-1:0] w_opb_sel;
  logic [WIDTH-1:0] w_opb_init;
  logic [DIGIT-1:0] w_s;
  logic             w_cout;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_res_next;

  assign w_ready   = (r_state != RUN);
  assign w_accept  = w_ready && start;
  assign w_last    = (r_state == RUN) && (r_cnt == LAST);
  assign w_is_sub  = (mode == MODE_SUB) || (mode == MODE_ACC_SUB);
  assign w_use_acc = (mode == MODE_ACC_ADD) || (mode == MODE_ACC_SUB);

  // A same-cycle clear takes precedence over the stored accumulator as operand.
  assign w_opb_sel  = w_use_acc ? (clr_acc ? '0 : r_acc) : B;
  assign w_opb_init = w_is_sub ? ~w_opb_sel : w_opb_sel;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a        (r_opa[DIGIT-1:0]),
    .b        (r_opb[DIGIT-1:0]),
    .cin      (r_carry),
    .s        (w_s),
    .cout     (w_cout),
    .c_msb_in (w_cmsb)
  );

  // New digit enters at the top; after STEPS shifts the word is in place.
  assign w_res_next = (r_res >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_res    <= '0;
      r_sum    <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_cr     <= 1'b0;
      r_ovf    <= 1'b0;
      r_to_acc <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_ready && clr_acc) r_acc <= '0;
      if (w_accept) begin
        r_opa    <= A;
        r_opb    <= w_opb_init;
        r_carry  <= w_is_sub;
        r_cnt    <= '0;
        r_to_acc <= w_use_acc;
      end else if (r_state == RUN) begin
        r_opa   <= r_opa >> DIGIT;
        r_opb   <= r_opb >> DIGIT;
        r_res   <= w_res_next;
        r_carry <= w_cout;
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_sum <= w_res_next;
          r_cr  <= w_cout;
          r_ovf <= w_cmsb ^ w_cout;
          if (r_to_acc) r_acc <= w_res_next;
        end
      end
    end
  end

  assign sum    = r_sum;
  assign cr_out = r_cr;
  assign ovf    = r_ovf;
  assign acc    = r_acc;
  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);

endmodule

// File: tb/tb_seq_accum_adder.sv
module tb_seq_accum_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, start16, clr8, clr16;
  logic [1:0]  mode8, mode16;
  logic [7:0]  A8, B8, sum8, acc8;
  logic [15:0] A16, B16, sum16, acc16;
  logic        cr8, ovf8, busy8, done8, cr16, ovf16, busy16, done16;

  seq_accum_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .clr_acc(clr8),
    .A(A8), .B(B8), .sum(sum8), .cr_out(cr8), .ovf(ovf8), .acc(acc8),
    .busy(busy8), .done(done8)
  );

  seq_accum_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .mode(mode16), .clr_acc(clr16),
    .A(A16), .B(B16), .sum(sum16), .cr_out(cr16), .ovf(ovf16), .acc(acc16),
    .busy(busy16), .done(done16)
  );

  int n_tot = 0;
  int n_bad = 0;
  logic [15:0] macc [2];

  typedef struct {
    logic [15:0] sum;
    logic        cr, ovf;
    logic [15:0] acc;
    logic        busy, done;
  } obs_t;

  typedef struct {
    bit          inst;
    logic [1:0]  md;
    logic        clr;
    logic [15:0] a, b;
    bit          b2b, poke;
    logic [15:0] es;
    logic        ec, ev;
    logic [15:0] eacc;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic obs_t peek(input bit inst);
    obs_t o;
    if (inst) begin
      o.sum = sum16; o.cr = cr16; o.ovf = ovf16; o.acc = acc16; o.busy = busy16; o.done = done16;
    end else begin
      o.sum = {8'h00, sum8}; o.cr = cr8; o.ovf = ovf8; o.acc = {8'h00, acc8};
      o.busy = busy8; o.done = done8;
    end
    return o;
  endfunction

  // Reference: plain integer arithmetic modulo 2^W; signed result range gives overflow.
  task automatic model(input bit inst, input logic [1:0] md, input logic [15:0] a, input logic [15:0] b,
                       input logic clr, output logic [15:0] es, output logic ec, output logic ev);
    int     w;
    longint m, ua, ub, full, sa, sb, r;
    w  = inst ? 16 : 8;
    m  = longint'(1) << w;
    ua = longint'(a) % m;
    ub = md[1] ? (clr ? 0 : longint'(macc[inst])) : (longint'(b) % m);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (md[0]) begin
      full = ua - ub; ec = (ua >= ub); r = sa - sb;
    end else begin
      full = ua + ub; ec = (full >= m); r = sa + sb;
    end
    es = 16'((full + m) % m);
    ev = (r >= m / 2) || (r < -(m / 2));
    if (md[1]) macc[inst] = es;
    else if (clr) macc[inst] = '0;
  endtask

  // Called at a negedge; returns at the negedge on which done is seen (or on budget expiry).
  task automatic run_op(input bit inst, input logic [1:0] md, input logic [15:0] a, input logic [15:0] b,
                        input logic clr, input bit poke, output obs_t o, output int lat,
                        output int bcnt, output bit moved);
    logic [15:0] s0;
    s0 = peek(inst).sum;
    if (inst) begin
      mode16 = md; clr16 = clr; A16 = a; B16 = b; start16 = 1'b1;
    end else begin
      mode8 = md; clr8 = clr; A8 = a[7:0]; B8 = b[7:0]; start8 = 1'b1;
    end
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0; clr8 = 1'b0; clr16 = 1'b0;
    lat = 0; bcnt = 0; moved = 1'b0;
    while (!peek(inst).done && lat < 64) begin
      if (peek(inst).busy) bcnt++;
      if (peek(inst).sum !== s0) moved = 1'b1;
      start8 = 1'b0; start16 = 1'b0;
      if (poke && lat == 1) begin
        if (inst) begin A16 = 16'hFFFF; start16 = 1'b1; end
        else      begin A8 = 8'hFF;     start8 = 1'b1;  end
      end
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0; start16 = 1'b0;
    o = peek(inst);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t        o;
    int          lat, bcnt, steps;
    bit          moved, prev_inst;
    logic [15:0] es;
    logic        ec, ev;

    rst = 1'b1; start8 = 0; start16 = 0; clr8 = 0; clr16 = 0;
    mode8 = 0; mode16 = 0; A8 = 0; B8 = 0; A16 = 0; B16 = 0;
    macc[0] = '0; macc[1] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset8",  {sum8, cr8, ovf8, acc8, busy8, done8}, 64'd0);
    chk("reset16", {sum16, cr16, ovf16, acc16, busy16, done16}, 64'd0);

    //          inst md     clr   a        b        b2b poke  sum      cr    ovf   acc
    vq.push_back('{0, 2'b00, 1'b0, 16'h5A,  16'h3C,  0, 0, 16'h96,   1'b0, 1'b1, 16'h00});
    vq.push_back('{0, 2'b00, 1'b0, 16'hFF,  16'h01,  0, 0, 16'h00,   1'b1, 1'b0, 16'h00});
    vq.push_back('{0, 2'b01, 1'b0, 16'h10,  16'h20,  1, 0, 16'hF0,   1'b0, 1'b0, 16'h00});
    vq.push_back('{0, 2'b10, 1'b1, 16'h7F,  16'h00,  0, 0, 16'h7F,   1'b0, 1'b0, 16'h7F});
    vq.push_back('{0, 2'b10, 1'b0, 16'h01,  16'h00,  1, 0, 16'h80,   1'b0, 1'b1, 16'h80});
    vq.push_back('{0, 2'b11, 1'b0, 16'h80,  16'h00,  1, 0, 16'h00,   1'b1, 1'b0, 16'h00});
    vq.push_back('{0, 2'b10, 1'b1, 16'h33,  16'h00,  0, 0, 16'h33,   1'b0, 1'b0, 16'h33});
    vq.push_back('{0, 2'b10, 1'b1, 16'h05,  16'h00,  1, 0, 16'h05,   1'b0, 1'b0, 16'h05});
    vq.push_back('{0, 2'b10, 1'b1, 16'h33,  16'h00,  0, 0, 16'h33,   1'b0, 1'b0, 16'h33});
    vq.push_back('{0, 2'b00, 1'b0, 16'h01,  16'h02,  0, 0, 16'h03,   1'b0, 1'b0, 16'h33});
    vq.push_back('{1, 2'b00, 1'b0, 16'h1234, 16'hEDCC, 0, 1, 16'h0000, 1'b1, 1'b0, 16'h0000});

    prev_inst = 0;
    foreach (vq[i]) begin
      if (!vq[i].b2b) begin
        @(negedge clk);
        if (i > 0) chk("done_pulse_len", peek(prev_inst).done, 1'b0);
      end
      steps = vq[i].inst ? 4 : 8;
      model(vq[i].inst, vq[i].md, vq[i].a, vq[i].b, vq[i].clr, es, ec, ev);
      run_op(vq[i].inst, vq[i].md, vq[i].a, vq[i].b, vq[i].clr, vq[i].poke, o, lat, bcnt, moved);
      chk($sformatf("vec%0d_latency", i), lat, steps);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, steps);
      chk($sformatf("vec%0d_sum_hold", i), moved, 1'b0);
      chk($sformatf("vec%0d_sum", i), o.sum, vq[i].es);
      chk($sformatf("vec%0d_cr", i), o.cr, vq[i].ec);
      chk($sformatf("vec%0d_ovf", i), o.ovf, vq[i].ev);
      chk($sformatf("vec%0d_acc", i), o.acc, vq[i].eacc);
      prev_inst = vq[i].inst;
    end

    // Reset during RUN: aborted operation, no done pulse, everything cleared.
    @(negedge clk);
    mode8 = 2'b00; A8 = 8'h12; B8 = 8'h34; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", {busy8, done8, sum8, acc8, cr8, ovf8}, 64'd0);
    macc[0] = '0; macc[1] = '0;
    begin
      int pulses;
      pulses = 0;
      repeat (12) begin
        @(negedge clk);
        if (done8) pulses++;
      end
      chk("abort_no_done", pulses, 0);
    end
    run_op(0, 2'b00, 16'h01, 16'h02, 1'b0, 0, o, lat, bcnt, moved);
    chk("after_abort_latency", lat, 8);
    chk("after_abort_sum", o.sum, 16'h03);

    // Randomized operations against the reference model, both geometries.
    for (int i = 0; i < 80; i++) begin
      bit          inst;
      logic [15:0] a, b, mask;
      logic [1:0]  md;
      logic        clr;
      inst = 1'($urandom_range(0, 1));
      mask = inst ? 16'hFFFF : 16'h00FF;
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk);
        if (inst) clr16 = 1'b1; else clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0; clr16 = 1'b0;
        macc[inst] = '0;
        chk($sformatf("rnd%0d_clr_acc", i), peek(inst).acc, 16'h0000);
      end else begin
        a   = 16'($urandom) & mask;
        b   = 16'($urandom) & mask;
        md  = 2'($urandom_range(0, 3));
        clr = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 0) @(negedge clk);
        model(inst, md, a, b, clr, es, ec, ev);
        run_op(inst, md, a, b, clr, 0, o, lat, bcnt, moved);
        chk($sformatf("rnd%0d_latency", i), lat, inst ? 4 : 8);
        chk($sformatf("rnd%0d_sum", i), o.sum, es);
        chk($sformatf("rnd%0d_cr", i), o.cr, ec);
        chk($sformatf("rnd%0d_ovf", i), o.ovf, ev);
        chk($sformatf("rnd%0d_acc", i), o.acc, macc[inst]);
      end
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
